// File: rtl/tm_access_arbiter.sv
// Shares the tape memory and rule-table port among the LCD reader, table loader and tape editor.
// LCD has fixed priority; loader/editor alternate; execute is granted only while idle in run mode.
module tm_access_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_start,
    input  logic        run_stop,
    input  logic        lcd_req,
    input  logic [10:0] lcd_addr,
    output logic        lcd_valid,
    output logic [1:0]  lcd_data,
    input  logic        ld_req,
    input  logic [10:0] ld_addr,
    input  logic [10:0] ld_data,
    output logic        ld_done,
    input  logic        ed_req,
    input  logic        ed_move,
    input  logic [10:0] ed_addr,
    input  logic [1:0]  ed_sym,
    input  logic        ed_dir,
    output logic        ed_done,
    output logic        execute,
    output logic        mem_access,
    output logic        mem_rw,
    output logic [10:0] mem_addr,
    output logic [1:0]  mem_wdata,
    output logic        head_dir,
    output logic        move_head,
    output logic        state_access,
    output logic [10:0] state_addr,
    output logic [10:0] state_in,
    input  logic [1:0]  mem_rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE, ST_ACK} state_t;
    typedef enum logic [1:0] {ID_LCD, ID_LD, ID_ED_WR, ID_ED_MV} req_id_t;

    state_t      state_reg;
    req_id_t     id_reg;
    logic        run_mode_reg;
    logic        ld_first_reg;
    logic        lcd_valid_reg;
    logic [1:0]  lcd_data_reg;
    logic        ld_done_reg;
    logic        ed_done_reg;
    logic        mem_access_reg;
    logic        mem_rw_reg;
    logic [10:0] mem_addr_reg;
    logic [1:0]  mem_wdata_reg;
    logic        head_dir_reg;
    logic        move_head_reg;
    logic        state_access_reg;
    logic [10:0] state_addr_reg;
    logic [10:0] state_in_reg;

    logic grant_lcd;
    logic grant_ld;
    logic grant_ed;

    // Loader and editor are locked out entirely while the machine is running.
    always_comb begin
        grant_lcd = lcd_req;
        grant_ld  = !lcd_req && !run_mode_reg && ld_req && (!ed_req || ld_first_reg);
        grant_ed  = !lcd_req && !run_mode_reg && ed_req && (!ld_req || !ld_first_reg);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            id_reg           <= ID_LCD;
            run_mode_reg     <= 1'b0;
            ld_first_reg     <= 1'b1;
            lcd_valid_reg    <= 1'b0;
            lcd_data_reg     <= 2'b00;
            ld_done_reg      <= 1'b0;
            ed_done_reg      <= 1'b0;
            mem_access_reg   <= 1'b0;
            mem_rw_reg       <= 1'b1;
            mem_addr_reg     <= '0;
            mem_wdata_reg    <= 2'b00;
            head_dir_reg     <= 1'b0;
            move_head_reg    <= 1'b0;
            state_access_reg <= 1'b0;
            state_addr_reg   <= '0;
            state_in_reg     <= '0;
        end else begin
            if (run_stop) begin
                run_mode_reg <= 1'b0;
            end else if (run_start && !run_mode_reg) begin
                run_mode_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (grant_lcd) begin
                        id_reg         <= ID_LCD;
                        mem_addr_reg   <= lcd_addr;
                        mem_access_reg <= 1'b1;
                        state_reg      <= ST_ISSUE;
                    end else if (grant_ld) begin
                        id_reg           <= ID_LD;
                        state_addr_reg   <= ld_addr;
                        state_in_reg     <= ld_data;
                        state_access_reg <= 1'b1;
                        ld_first_reg     <= 1'b0;
                        state_reg        <= ST_ISSUE;
                    end else if (grant_ed) begin
                        id_reg        <= ed_move ? ID_ED_MV : ID_ED_WR;
                        mem_addr_reg  <= ed_addr;
                        mem_wdata_reg <= ed_sym;
                        head_dir_reg  <= ed_dir;
                        ld_first_reg  <= 1'b1;
                        state_reg     <= ST_ISSUE;
                        if (ed_move) begin
                            move_head_reg <= 1'b1;
                        end else begin
                            mem_access_reg <= 1'b1;
                            mem_rw_reg     <= 1'b0;
                        end
                    end
                end
                ST_ISSUE: begin
                    mem_access_reg   <= 1'b0;
                    mem_rw_reg       <= 1'b1;
                    move_head_reg    <= 1'b0;
                    state_access_reg <= 1'b0;
                    if (id_reg == ID_LCD) begin
                        state_reg <= ST_CAPTURE;
                    end else begin
                        ld_done_reg <= (id_reg == ID_LD);
                        ed_done_reg <= (id_reg == ID_ED_WR) || (id_reg == ID_ED_MV);
                        state_reg   <= ST_ACK;
                    end
                end
                ST_CAPTURE: begin
                    // Tape memory returns read data one cycle after the access strobe.
                    lcd_data_reg  <= mem_rdata;
                    lcd_valid_reg <= 1'b1;
                    state_reg     <= ST_ACK;
                end
                ST_ACK: begin
                    lcd_valid_reg <= 1'b0;
                    ld_done_reg   <= 1'b0;
                    ed_done_reg   <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign execute      = run_mode_reg && (state_reg == ST_IDLE);
    assign lcd_valid    = lcd_valid_reg;
    assign lcd_data     = lcd_data_reg;
    assign ld_done      = ld_done_reg;
    assign ed_done      = ed_done_reg;
    assign mem_access   = mem_access_reg;
    assign mem_rw       = mem_rw_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_wdata    = mem_wdata_reg;
    assign head_dir     = head_dir_reg;
    assign move_head    = move_head_reg;
    assign state_access = state_access_reg;
    assign state_addr   = state_addr_reg;
    assign state_in     = state_in_reg;

endmodule

// File: doc/tm_access_arbiter.md
TM_ACCESS_ARBITER -- requirements
Module: tm_access_arbiter

Interface
REQ-001 SHALL have: clk  input  1  single clock; all logic on posedge clk.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: run_start / run_stop  input  1 each  single-cycle run-mode set/clear pulses.
REQ-004 SHALL have: lcd_req  input  1; lcd_addr  input  11; lcd_valid  output  1; lcd_data  output  2  (LCD tape-read requester).
REQ-005 SHALL have: ld_req  input  1; ld_addr  input  11; ld_data  input  11; ld_done  output  1  (rule-table loader requester).
REQ-006 SHALL have: ed_req  input  1; ed_move  input  1 (1=head move only, 0=tape write); ed_addr  input  11; ed_sym  input  2; ed_dir  input  1; ed_done  output  1  (tape editor requester).
REQ-007 SHALL have machine-side outputs: execute 1, mem_access 1, mem_rw 1 (1=read), mem_addr 11, mem_wdata 2, head_dir 1, move_head 1, state_access 1, state_addr 11, state_in 11; and input mem_rdata 2.

Function
REQ-008 SHALL implement FSM IDLE, ISSUE, CAPTURE, ACK; every machine-side strobe is a decode of registered state/registers only, never of same-cycle inputs.
REQ-009 SHALL sample requests only in IDLE; priority: LCD highest, then loader/editor round-robin.
REQ-010 SHALL, with ld_req and ed_req both pending and no lcd_req, grant the one not granted most recently; pointer updates on each loader/editor grant only.
REQ-011 SHALL, on grant, latch the winner's address/data/dir/move fields and requester ID, and move IDLE->ISSUE next cycle.
REQ-012 SHALL in ISSUE assert for exactly one cycle: LCD: mem_access=1, mem_rw=1; loader: state_access=1; editor write: mem_access=1, mem_rw=0, mem_wdata=ed_sym, head_dir=ed_dir; editor move: move_head=1, head_dir=ed_dir.
REQ-013 SHALL hold mem_addr/state_addr/state_in/mem_wdata/head_dir stable from ISSUE through ACK.
REQ-014 SHALL for LCD go ISSUE->CAPTURE->ACK, registering mem_rdata into lcd_data in CAPTURE; all others go ISSUE->ACK.
REQ-015 SHALL in ACK pulse exactly one of lcd_valid/ld_done/ed_done for one cycle, then return to IDLE; lcd_data holds until next LCD capture.
REQ-016 SHALL give latencies from grant (IDLE) cycle: LCD ack 3 cycles later; loader/editor ack 2 cycles later.
REQ-017 SHALL keep mem_rw=1 and all strobes 0 outside ISSUE.
REQ-018 SHALL set run_mode on run_start only when run_mode=0, clear on run_stop; run_stop has priority on simultaneous pulses.
REQ-019 SHALL drive execute = run_mode AND state==IDLE; execute is 0 throughout any transaction.
REQ-020 SHALL, while run_mode=1, serve LCD requests only; ld_req/ed_req stay pending, ungranted, no done pulse.
REQ-021 SHALL let run_stop mid-transaction complete that transaction normally; execute stays 0 afterward.
REQ-022 SHALL treat a requester deasserting req after grant as no-op: transaction and ack still complete.
REQ-023 SHALL require requesters to hold req until their ack; a req still high in the IDLE cycle after ack is a new request.

Reset
REQ-024 SHALL on rst=1 at a clock edge: state=IDLE, run_mode=0, execute=0, all strobes/acks 0, mem_rw=1, lcd_data=0, addr/data registers 0, round-robin pointer favours loader first.
REQ-025 SHALL abort any transaction when rst asserts mid-operation, with no ack emitted.

Verification
REQ-026 LCD read: lcd_req=1, lcd_addr=0x200, mem_rdata=2'b10 -> one-cycle mem_access/mem_rw=1 with mem_addr=0x200, then lcd_valid=1, lcd_data=2'b10 exactly 3 cycles after grant.
REQ-027 Contention: ld_req, ed_req, lcd_req same cycle -> order LCD, loader, editor; with ld_req/ed_req held continuously, grants alternate loader, editor, loader.
REQ-028 Loader write: ld_addr=0x005, ld_data=0x501 -> single state_access pulse with state_addr=0x005, state_in=0x501; ld_done 2 cycles after grant.
REQ-029 Run gating: run_start, then ed_req=1 and lcd_req=1 -> execute=1 except during LCD transaction (drops 3 cycles); ed_req not granted until run_stop, then ed_done follows.
REQ-030 Editor move vs write: ed_move=1, ed_dir=1 -> move_head pulse, no mem_access; ed_move=0, ed_sym=2'b11 -> mem_access with mem_rw=0, mem_wdata=2'b11.
REQ-031 Reset mid-read: rst=1 during CAPTURE -> next cycle IDLE, lcd_valid never pulses, execute=0, mem_rw=1.
